// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment frame decoder: active-low digit
// patterns (a..g, a at MSB) and the frame checker state encoding.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2,
        ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern to a hex nibble.
// ALLOW_BLANK selects whether an all-off digit reads as 0 or as undecodable.
module seg7_digit_decode
    import seg7_pkg::*;
#(
    parameter bit ALLOW_BLANK = 1'b0
) (
    input  logic [SEG_W-1:0] pat_i,
    output logic [NIB_W-1:0] nibble_c,
    output logic             ok_c
);

    always_comb begin
        nibble_c = '0;
        ok_c     = 1'b1;
        case (pat_i)
            SEG_0:     nibble_c = 4'h0;
            SEG_1:     nibble_c = 4'h1;
            SEG_2:     nibble_c = 4'h2;
            SEG_3:     nibble_c = 4'h3;
            SEG_4:     nibble_c = 4'h4;
            SEG_5:     nibble_c = 4'h5;
            SEG_6:     nibble_c = 4'h6;
            SEG_7:     nibble_c = 4'h7;
            SEG_8:     nibble_c = 4'h8;
            SEG_9:     nibble_c = 4'h9;
            SEG_A:     nibble_c = 4'hA;
            SEG_B:     nibble_c = 4'hB;
            SEG_C:     nibble_c = 4'hC;
            SEG_D:     nibble_c = 4'hD;
            SEG_E:     nibble_c = 4'hE;
            SEG_F:     nibble_c = 4'hF;
            SEG_BLANK: ok_c     = ALLOW_BLANK;
            default:   ok_c     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Two-digit seven-segment frame decoder with a +1 sequence checker.
// Stage 1 captures the raw frame; stage 2 registers the decode and FSM result.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned LOCK_RUN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [13:0] seg_in,
    input  logic        seg_valid,
    output logic [7:0]  value,
    output logic        value_valid,
    output logic        bad_pat,
    output logic        locked,
    output logic        err,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned RUN_W = 8;

    // Asynchronous assert, clock-aligned release of the internal reset.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [13:0]      s1_seg_q, s1_seg_d;
    logic             s1_vld_q, s1_vld_d;
    state_e           state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [7:0]       value_q, value_d;
    logic             value_valid_q, value_valid_d;
    logic             bad_pat_q, bad_pat_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [NIB_W-1:0] hi_nib, lo_nib;
    logic             hi_ok, lo_ok;
    logic             frame_ok;
    logic [7:0]       frame_val;

    seg7_digit_decode #(.ALLOW_BLANK(1'b1)) u_dec_hi (
        .pat_i    (s1_seg_q[13:7]),
        .nibble_c (hi_nib),
        .ok_c     (hi_ok)
    );

    seg7_digit_decode #(.ALLOW_BLANK(1'b0)) u_dec_lo (
        .pat_i    (s1_seg_q[6:0]),
        .nibble_c (lo_nib),
        .ok_c     (lo_ok)
    );

    assign frame_ok  = hi_ok & lo_ok;
    assign frame_val = {hi_nib, lo_nib};
    assign run_inc   = run_q + RUN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_seg_q      <= '0;
            s1_vld_q      <= 1'b0;
            state_q       <= IDLE;
            exp_q         <= '0;
            run_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            bad_pat_q     <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            s1_seg_q      <= s1_seg_d;
            s1_vld_q      <= s1_vld_d;
            state_q       <= state_d;
            exp_q         <= exp_d;
            run_q         <= run_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            bad_pat_q     <= bad_pat_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state: clr wins over both stages; otherwise stage-1 frame drives the checker.
    always_comb begin
        s1_seg_d      = seg_in;
        s1_vld_d      = seg_valid & ~clr;
        state_d       = state_q;
        exp_d         = exp_q;
        run_d         = run_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        bad_pat_d     = 1'b0;
        cnt_d         = cnt_q;

        if (clr) begin
            state_d = IDLE;
            exp_d   = '0;
            run_d   = '0;
            cnt_d   = '0;
        end else if (s1_vld_q) begin
            if (!frame_ok) begin
                bad_pat_d = 1'b1;
                state_d   = ERR;
            end else begin
                value_valid_d = 1'b1;
                value_d       = frame_val;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                case (state_q)
                    IDLE: begin
                        exp_d   = frame_val + 8'd1;
                        run_d   = '0;
                        state_d = SYNC;
                    end
                    SYNC: begin
                        exp_d = frame_val + 8'd1;
                        if (frame_val == exp_q) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_RUN)) state_d = LOCK;
                        end else begin
                            run_d = '0;
                        end
                    end
                    LOCK: begin
                        if (frame_val == exp_q) exp_d = frame_val + 8'd1;
                        else                    state_d = ERR;
                    end
                    default: state_d = ERR;
                endcase
            end
        end
    end

    assign locked_d = (state_d == LOCK);
    assign err_d    = (state_d == ERR);

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign bad_pat     = bad_pat_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: a behavioural model predicts each
// frame's outcome at drive time; a negedge monitor pops and compares strobes.
module tb_seg7_frame_decoder;

    localparam int LOCK_RUN = 2;

    localparam logic [6:0] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [7:0] value;
        logic       vv;
        logic       bad;
        logic       locked;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [13:0] seg_in;
    logic        seg_valid;
    logic [7:0]  value;
    logic        value_valid;
    logic        bad_pat;
    logic        locked;
    logic        err;
    logic [7:0]  frame_cnt;

    int n_total = 0;
    int n_pass  = 0;

    exp_t sb [$];

    int         m_state;
    int         m_run;
    logic [7:0] m_exp;
    logic [7:0] m_val;
    logic [7:0] m_cnt;

    seg7_frame_decoder #(.LOCK_RUN(LOCK_RUN)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .seg_in      (seg_in),
        .seg_valid   (seg_valid),
        .value       (value),
        .value_valid (value_valid),
        .bad_pat     (bad_pat),
        .locked      (locked),
        .err         (err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    function automatic bit dec(input logic [6:0] p, input bit hi, output logic [3:0] n);
        n = 4'h0;
        if (hi && p == 7'h7F) return 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (PAT[i] == p) begin
                n = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [13:0] enc(input logic [7:0] v);
        return {PAT[v[7:4]], PAT[v[3:0]]};
    endfunction

    function automatic void model_clr();
        m_state = 0;
        m_run   = 0;
        m_exp   = 8'h00;
        m_cnt   = 8'h00;
    endfunction

    function automatic exp_t model_frame(input logic [13:0] f);
        exp_t       e;
        logic [3:0] nh, nl;
        bit         okh, okl;
        logic [7:0] v;
        okh = dec(f[13:7], 1'b1, nh);
        okl = dec(f[6:0], 1'b0, nl);
        if (!(okh && okl)) begin
            m_state = 3;
            e.vv    = 1'b0;
            e.bad   = 1'b1;
        end else begin
            v     = {nh, nl};
            e.vv  = 1'b1;
            e.bad = 1'b0;
            m_val = v;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            case (m_state)
                0: begin m_exp = v + 8'd1; m_run = 0; m_state = 1; end
                1: begin
                    if (v == m_exp) begin
                        m_run++;
                        if (m_run >= LOCK_RUN) m_state = 2;
                    end else begin
                        m_run = 0;
                    end
                    m_exp = v + 8'd1;
                end
                2: begin
                    if (v == m_exp) m_exp = v + 8'd1;
                    else            m_state = 3;
                end
                default: ;
            endcase
        end
        e.value  = m_val;
        e.locked = (m_state == 2);
        e.err    = (m_state == 3);
        e.cnt    = m_cnt;
        return e;
    endfunction

    // Drive one frame for one cycle; entered and left at posedge+1.
    task automatic send(input logic [13:0] f);
        sb.push_back(model_frame(f));
        seg_in    = f;
        seg_valid = 1'b1;
        @(posedge clk);
        #1 seg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clr();
        check("clr_err", 32'(err), 32'd0);
        check("clr_locked", 32'(locked), 32'd0);
        check("clr_cnt", 32'(frame_cnt), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, 32'(value), 32'd0);
        check({tag, "_vv"}, 32'(value_valid), 32'd0);
        check({tag, "_bad"}, 32'(bad_pat), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // Every strobe must match the oldest prediction; unpredicted strobes fail.
    always @(negedge clk) begin
        exp_t e;
        if (value_valid || bad_pat) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, value_valid, bad_pat}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("value", 32'(value), 32'(e.value));
                check("value_valid", 32'(value_valid), 32'(e.vv));
                check("bad_pat", 32'(bad_pat), 32'(e.bad));
                check("locked", 32'(locked), 32'(e.locked));
                check("err", 32'(err), 32'(e.err));
                check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        seg_in    = '0;
        seg_valid = 1'b0;
        model_clr();
        m_val = 8'h00;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        idle(5);

        // Lock-in with blank high digit
        send(14'h3F81);
        send(14'h3FCF);
        send(14'h3F92);
        send(14'h3F86);
        drain();
        check("lockin_locked", 32'(locked), 32'd1);
        check("lockin_cnt", 32'(frame_cnt), 32'd4);

        // Sequence error while locked: 5 after 3
        send(enc(8'h05));
        drain();
        check("seqerr_err", 32'(err), 32'd1);
        check("seqerr_locked", 32'(locked), 32'd0);
        do_clr();

        // clr drops a frame already in stage 1
        seg_in    = enc(8'h40);
        seg_valid = 1'b1;
        @(posedge clk);
        #1 seg_valid = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clr();
        idle(4);
        check("clrdrop_cnt", 32'(frame_cnt), 32'd0);

        // Relock from IDLE, then an undecodable low digit
        send(enc(8'h10));
        send(enc(8'h11));
        send(enc(8'h12));
        send({PAT[1], 7'b1010101});
        drain();
        check("badpat_value_held", 32'(value), 32'h12);
        check("badpat_err", 32'(err), 32'd1);
        do_clr();

        // Blank low digit is undecodable
        send({PAT[2], 7'b1111111});
        drain();
        check("lowblank_err", 32'(err), 32'd1);
        do_clr();

        // Wrap-around 0xFF -> 0x00 while locked
        send(enc(8'hFC));
        send(enc(8'hFD));
        send(enc(8'hFE));
        send(enc(8'hFF));
        send(enc(8'h00));
        send(enc(8'h01));
        drain();
        check("wrap_err", 32'(err), 32'd0);
        check("wrap_locked", 32'(locked), 32'd1);

        // Frame counter saturation at full throughput
        for (int i = 0; i < 256; i++) send(enc(8'(i + 2)));
        drain();
        check("sat_cnt", 32'(frame_cnt), 32'hFF);
        check("sat_locked", 32'(locked), 32'd1);

        // Asynchronous reset while locked with a frame in stage 1
        seg_in    = enc(8'h02);
        seg_valid = 1'b1;
        @(posedge clk);
        #1 seg_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check_zero("midrst");
        model_clr();
        m_val = 8'h00;
        idle(3);
        rst = 1'b1;
        idle(5);
        check_zero("postrst");

        // Back to normal operation from IDLE
        send(enc(8'h20));
        send(enc(8'h21));
        send(enc(8'h22));
        drain();
        check("final_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 SHALL have parameter LOCK_RUN, default 2, meaning the number of consecutive +1 frames needed to move from SYNC to LOCK.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is clocked on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port clr, input, 1, synchronous clear of the checker state and counters.
REQ-005 SHALL have port seg_in, input, 14, two active-low digit patterns: [13:7] is the high digit and [6:0] the low digit, each in a..g order with a at the MSB.
REQ-006 SHALL have port seg_valid, input, 1, qualifying seg_in for one cycle.
REQ-007 SHALL have port value, output, 8, the decoded frame as {hi nibble, lo nibble}.
REQ-008 SHALL have port value_valid, output, 1, a one-cycle strobe marking a new value.
REQ-009 SHALL have port bad_pat, output, 1, a one-cycle strobe flagging an undecodable pattern in the frame.
REQ-010 SHALL have port locked, output, 1, high while the FSM is in LOCK.
REQ-011 SHALL have port err, output, 1, a sticky sequence or pattern error.
REQ-012 SHALL have port frame_cnt, output, 8, counting accepted decodable frames and saturating at 0xFF.

Function
REQ-013 SHALL decode each 7-bit group with this table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-014 SHALL decode high-digit blank (1111111) as nibble 0; low-digit blank SHALL be an undecodable pattern.
REQ-015 SHALL treat any other pattern as undecodable.
REQ-016 SHALL use a two-stage pipeline: stage 1 registers seg_in/seg_valid, stage 2 registers the decode result, for a latency of 2 cycles from seg_valid to value_valid or bad_pat.
REQ-017 SHALL assert exactly one of value_valid or bad_pat per valid frame; seg_valid frames on back-to-back cycles SHALL all be processed at full throughput.
REQ-018 SHALL hold value at the last good frame when bad_pat fires.
REQ-019 SHALL implement FSM states IDLE, SYNC, LOCK, ERR with these transitions:
- IDLE: a good frame stores expected=value+1 and goes to SYNC.
- SYNC: a match increments run; when run==LOCK_RUN go to LOCK; a mismatch reloads expected and sets run=0 while staying in SYNC.
- LOCK: a match updates expected; a mismatch goes to ERR.
- Any state: a bad pattern goes to ERR.
- ERR: stays in ERR until clr, which goes to IDLE.
REQ-020 SHALL compute expected modulo 256, so that 0xFF is followed by 0x00 and counts as a match.
REQ-021 SHALL register locked and err from the next state, so they update in the same cycle as the value_valid or bad_pat that caused the change.
REQ-022 SHALL give clr priority over any frame in both pipeline stages: in-flight frames are dropped, no strobes are emitted, and the next cycle has state IDLE, frame_cnt=0 and err=0.

Reset
REQ-023 SHALL, while rst=0, drive value=0x00, value_valid=0, bad_pat=0, locked=0, err=0 and frame_cnt=0, with the FSM in IDLE and both pipeline valids at 0.
REQ-024 SHALL take effect on reset assertion regardless of clk, including mid-LOCK; frames in flight are discarded.
REQ-025 SHALL deassert reset synchronously to clk at the block's reset synchronizer.

Structure
REQ-026 SHALL place the 16 digit pattern constants, the blank constant and the FSM state enum in shared package seg7_pkg.
REQ-027 SHALL use one purely combinational sub-module, seg7_digit_decode (7-bit pattern to 4-bit nibble plus ok flag), instantiated twice.

Verification
REQ-028 SHALL check reset: with rst=0 and clk running, all outputs read 0 and locked=0.
REQ-029 SHALL check lock-in: frames 0x3F81, 0x3FCF, 0x3F92, 0x3F86 on consecutive cycles give value 0x00..0x03 at latency 2, with locked=1 coinciding with value 0x02 and frame_cnt=4.
REQ-030 SHALL check sequence error: while locked, sending value 5 after 3 gives err=1 and locked=0; a later clr returns to IDLE with err=0.
REQ-031 SHALL check bad pattern: low digit 1010101 gives bad_pat for one cycle, value held, and err=1.
REQ-032 SHALL check wrap-around: frames 0xFE, 0xFF, 0x00, with hi digit F=0111000, give no error while locked.
REQ-033 SHALL check reset mid-operation: rst=0 while locked with a frame in flight gives no strobe afterwards and all outputs at 0.
